// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  localparam logic [6:0]  SEG_BLANK  = '1;
  localparam logic [3:0]  AN_OFF     = '1;
  localparam int unsigned NUM_DIGITS = 4;

  // Per-position suppression flags for leading-zero blanking; digit0 never blanks.
  function automatic logic [3:0] lz_mask(input logic [3:0] d3, input logic [3:0] d2,
                                         input logic [3:0] d1);
    logic [3:0] m;
    m[3] = (d3 == 4'h0);
    m[2] = m[3] && (d2 == 4'h0);
    m[1] = m[2] && (d1 == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex digit to active-low segment pattern; seg = {g,f,e,d,c,b,a}.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit common-anode scan sequencer with anti-ghost blanking and frame-aligned updates.
// Optional PWM dimming via `define SEVEN_SEG_PWM_EN (adds duty input).
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       lz_blank,
`ifdef SEVEN_SEG_PWM_EN
  input  logic [3:0] duty,
`endif
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic       upd_valid,
  output logic       upd_ready,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int unsigned SLOT_W = $clog2(CLK_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
  localparam bit NO_BLANK = (BLANK_CYCLES == 0);

  state_t                          state, state_nxt;
  logic [SLOT_W-1:0]               slot_cnt, slot_nxt;
  logic [1:0]                      idx, idx_nxt;
  logic [NUM_DIGITS-1:0][3:0]      shadow;
  logic [3:0]                      supp;
  logic [6:0]                      dec_seg;
  logic [6:0]                      seg_nxt;
  logic [3:0]                      an_nxt;
  logic                            slot_end, frame_end, drive_on, an_on;

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = (state == DRIVE) && slot_end && (idx == 2'd3);
  assign upd_ready = (state == IDLE) || frame_end;
  assign supp      = lz_mask(shadow[3], shadow[2], shadow[1]);
  assign drive_on  = enable && (state == DRIVE);

`ifdef SEVEN_SEG_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign an_on = drive_on && (pwm_cnt <= duty);
`else
  assign an_on = drive_on;
`endif

  seven_seg_decoder u_dec (
    .value (shadow[idx]),
    .seg   (dec_seg)
  );

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_cnt;
    idx_nxt   = idx;
    if (!enable) begin
      state_nxt = IDLE;
      slot_nxt  = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = NO_BLANK ? DRIVE : BLANK;
          slot_nxt  = '0;
          idx_nxt   = '0;
        end
        BLANK: begin
          slot_nxt = slot_cnt + SLOT_W'(1);
          if (slot_cnt == BLANK_LAST) state_nxt = DRIVE;
        end
        DRIVE: begin
          if (slot_end) begin
            slot_nxt  = '0;
            idx_nxt   = idx + 2'd1;
            state_nxt = NO_BLANK ? DRIVE : BLANK;
          end else begin
            slot_nxt = slot_cnt + SLOT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          slot_nxt  = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Gating by enable makes a mid-slot disable dark on the very next edge.
  always_comb begin
    an_nxt  = an_on ? ~(4'b0001 << idx) : AN_OFF;
    seg_nxt = (drive_on && !(lz_blank && supp[idx])) ? dec_seg : SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      slot_cnt   <= '0;
      idx        <= '0;
      shadow     <= '0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      slot_cnt   <= slot_nxt;
      idx        <= idx_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_tick <= frame_end && enable;
      if (upd_valid && upd_ready) shadow <= {digit3, digit2, digit1, digit0};
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: CLK_DIV=8 with BLANK_CYCLES=2 and BLANK_CYCLES=0 instances in parallel.
module tb_seven_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       lz_blank;
  logic [3:0] d0, d1, d2, d3;
  logic       upd_valid;
  logic       rdy, tick, rdy_nb, tick_nb;
  logic [6:0] seg, seg_nb;
  logic [3:0] an, an_nb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lz_blank(lz_blank),
`ifdef SEVEN_SEG_PWM_EN
    .duty(4'hF),
`endif
    .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
    .upd_valid(upd_valid), .upd_ready(rdy), .seg(seg), .an(an), .frame_tick(tick)
  );

  seven_seg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lz_blank(lz_blank),
`ifdef SEVEN_SEG_PWM_EN
    .duty(4'hF),
`endif
    .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
    .upd_valid(upd_valid), .upd_ready(rdy_nb), .seg(seg_nb), .an(an_nb), .frame_tick(tick_nb)
  );

  typedef struct {
    logic [15:0]     digits;
    logic            lz;
    logic [3:0][6:0] segs;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       tick;
    logic       rdy;
    logic [3:0] an_nb;
    logic [6:0] seg_nb;
    logic       tick_nb;
  } exp_t;

  localparam logic [6:0] BL = 7'b1111111;

  vec_t vecs[8];
  vec_t zero_vec;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Output after edge k reflects the state held after edge k-1 (m = k-1).
  function automatic void model(input int m, input int blank, input logic [3:0][6:0] segs,
                                output logic [3:0] e_an, output logic [6:0] e_seg,
                                output logic e_tick);
    int pos, slot;
    e_an = 4'hF; e_seg = BL; e_tick = 1'b0;
    if (m >= 0) begin
      pos    = m % 8;
      slot   = (m / 8) % 4;
      e_tick = ((m % 32) == 31);
      if (pos >= blank) begin
        e_an  = ~(4'b0001 << slot);
        e_seg = segs[slot];
      end
    end
  endfunction

  task automatic go_idle();
    enable = 1'b0;
    @(posedge clk); #1;
    chk("idle_an", 32'(an), 32'hF);
  endtask

  task automatic load(input logic [15:0] v);
    chk("load_ready", 32'(rdy), 32'h1);
    {d3, d2, d1, d0} = v;
    upd_valid = 1'b1;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic run_scan(input vec_t a, input vec_t b, input int upd_at, input int ncyc);
    exp_t e, g;
    logic [3:0][6:0] segs;
    lz_blank = a.lz;
    enable   = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      segs = (upd_at >= 0 && (k - 1) >= 32) ? b.segs : a.segs;
      model(k - 1, 2, segs, e.an, e.seg, e.tick);
      model(k - 1, 0, segs, e.an_nb, e.seg_nb, e.tick_nb);
      e.rdy = ((k % 32) == 31);
      sb.push_back(e);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        g = sb.pop_front();
        chk("an", 32'(an), 32'(g.an));
        chk("seg", 32'(seg), 32'(g.seg));
        chk("frame_tick", 32'(tick), 32'(g.tick));
        chk("upd_ready", 32'(rdy), 32'(g.rdy));
        chk("nb_an", 32'(an_nb), 32'(g.an_nb));
        chk("nb_seg", 32'(seg_nb), 32'(g.seg_nb));
        chk("nb_frame_tick", 32'(tick_nb), 32'(g.tick_nb));
        chk("nb_upd_ready", 32'(rdy_nb), 32'(g.rdy));
      end
      if (k == upd_at) begin
        {d3, d2, d1, d0} = b.digits;
        upd_valid = 1'b1;
      end
      if (upd_at >= 0 && k == 32) upd_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{16'h4321, 1'b0, {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}};
    vecs[1] = '{16'h0050, 1'b1, {BL,         BL,         7'b0010010, 7'b1000000}};
    vecs[2] = '{16'h0050, 1'b0, {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000}};
    vecs[3] = '{16'h0007, 1'b1, {BL,         BL,         BL,         7'b1111000}};
    vecs[4] = '{16'h0000, 1'b1, {BL,         BL,         BL,         7'b1000000}};
    vecs[5] = '{16'h80AF, 1'b1, {7'b0000000, 7'b1000000, 7'b0001000, 7'b0001110}};
    vecs[6] = '{16'h0C0E, 1'b1, {BL,         7'b1000110, 7'b1000000, 7'b0000110}};
    vecs[7] = '{16'h96DB, 1'b1, {7'b0010000, 7'b0000010, 7'b0100001, 7'b0000011}};
    zero_vec = '{16'h0000, 1'b0, {4{7'b1000000}}};

    rst_n = 1'b0; enable = 1'b0; lz_blank = 1'b0; upd_valid = 1'b0;
    {d3, d2, d1, d0} = '0;
    #12;
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_seg", 32'(seg), 32'(BL));
    chk("reset_tick", 32'(tick), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      go_idle();
      load(vecs[i].digits);
      run_scan(vecs[i], vecs[i], -1, (i == 0) ? 66 : 34);
    end

    // Update requested mid-frame must only take effect from the next frame.
    go_idle();
    load(vecs[0].digits);
    run_scan(vecs[0], vecs[7], 10, 66);

    // Disable during DRIVE of idx 2, then restart from idx 0.
    go_idle();
    load(vecs[0].digits);
    run_scan(vecs[0], vecs[0], -1, 21);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("dis_an", 32'(an), 32'hF);
    chk("dis_seg", 32'(seg), 32'(BL));
    chk("dis_nb_an", 32'(an_nb), 32'hF);
    chk("dis_ready", 32'(rdy), 32'h1);
    run_scan(vecs[0], vecs[0], -1, 12);

    // Asynchronous reset mid-DRIVE clears outputs immediately and the shadow.
    go_idle();
    load(vecs[5].digits);
    run_scan(vecs[5], vecs[5], -1, 13);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_seg", 32'(seg), 32'(BL));
    chk("arst_nb_an", 32'(an_nb), 32'hF);
    chk("arst_nb_seg", 32'(seg_nb), 32'(BL));
    enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_scan(zero_vec, zero_vec, -1, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
